// File: rtl/g3_table_updater.sv
// Write-side controller for a G3 rule table: serialises INSERT/DELETE commands into
// single-cycle entry writes, keeps next-pointer chains intact and manages slot allocation.
module g3_table_updater #(
  parameter int unsigned TABLE_ENTRY_SIZE = 2047,
  parameter int unsigned INDEX_BIT_LEN    = 11,
  parameter int unsigned ENTRY_DATA_WIDTH = 171,
  parameter int unsigned COMMAND_BIT_LEN  = 2,
  parameter int unsigned INIT_USED        = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [COMMAND_BIT_LEN-1:0]  cmd_op,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_prev,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_target,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_rule_id,
  input  logic [148:0]                cmd_fields,
  output logic                        we,
  output logic [ENTRY_DATA_WIDTH-1:0] din,
  output logic [INDEX_BIT_LEN-1:0]    wr_index,
  output logic                        done,
  output logic [1:0]                  status,
  output logic [INDEX_BIT_LEN-1:0]    alloc_index
);
  localparam int unsigned DEPTH = TABLE_ENTRY_SIZE + 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = INDEX_BIT_LEN + 1;
  localparam int unsigned LOW   = ENTRY_DATA_WIDTH - INDEX_BIT_LEN;
  localparam logic [CW-1:0] TES_C  = CW'(TABLE_ENTRY_SIZE);
  localparam logic [CW-1:0] INIT_C = CW'(INIT_USED);

  localparam logic [COMMAND_BIT_LEN-1:0] OP_NOP = COMMAND_BIT_LEN'(0);
  localparam logic [COMMAND_BIT_LEN-1:0] OP_INS = COMMAND_BIT_LEN'(1);
  localparam logic [COMMAND_BIT_LEN-1:0] OP_DEL = COMMAND_BIT_LEN'(2);
  localparam logic [COMMAND_BIT_LEN-1:0] OP_RSV = COMMAND_BIT_LEN'(3);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_FULL = 2'b01;
  localparam logic [1:0] ST_LINK = 2'b10;
  localparam logic [1:0] ST_BAD  = 2'b11;

  typedef enum logic [2:0] {IDLE, READ, WR_NEW, WR_PREV, WR_CLR, DONE} state_t;
  state_t state, state_nx;

  logic [ENTRY_DATA_WIDTH-1:0] shadow     [DEPTH];
  logic [INDEX_BIT_LEN-1:0]    free_stack [DEPTH];

  logic [COMMAND_BIT_LEN-1:0] op_r;
  logic [INDEX_BIT_LEN-1:0]   prev_r, target_r, rule_r, f_r, tgt_next;
  logic [148:0]               fields_r;
  logic [LOW-1:0]             prev_low;
  logic [CW-1:0]              sp, bump, sp_dec;

  logic [ENTRY_DATA_WIDTH-1:0] rd_prev;
  logic [INDEX_BIT_LEN-1:0]    rd_prev_next, rd_tgt_next, f_sel;
  logic have_free, bump_ok, prev_bad, tgt_bad;
  logic pop, take_bump, push;

  logic                        we_nx, done_nx;
  logic [ENTRY_DATA_WIDTH-1:0] din_nx;
  logic [INDEX_BIT_LEN-1:0]    idx_nx;
  logic [1:0]                  status_nx;

  assign rd_prev      = shadow[prev_r[AW-1:0]];
  assign rd_prev_next = rd_prev[ENTRY_DATA_WIDTH-1 -: INDEX_BIT_LEN];
  assign rd_tgt_next  = shadow[target_r[AW-1:0]][ENTRY_DATA_WIDTH-1 -: INDEX_BIT_LEN];
  assign sp_dec       = sp - 1'b1;
  assign have_free    = (sp != '0);
  assign bump_ok      = (bump <= TES_C);
  assign f_sel        = have_free ? free_stack[sp_dec[AW-1:0]] : bump[INDEX_BIT_LEN-1:0];
  assign prev_bad     = (prev_r == '0) || ({1'b0, prev_r} > TES_C);
  assign tgt_bad      = (op_r == OP_DEL) && ((target_r == '0) || ({1'b0, target_r} > TES_C));
  assign push         = (state == WR_CLR);

  // Outputs are registered from next-state decode, so write data for a state is built one cycle early.
  always_comb begin
    state_nx  = state;
    we_nx     = 1'b0;
    din_nx    = '0;
    idx_nx    = '0;
    done_nx   = 1'b0;
    status_nx = status;
    pop       = 1'b0;
    take_bump = 1'b0;
    unique case (state)
      IDLE: if (cmd_valid) state_nx = READ;
      READ: begin
        state_nx = DONE;
        done_nx  = 1'b1;
        if (op_r == OP_RSV || prev_bad || tgt_bad) begin
          status_nx = ST_BAD;
        end else if (op_r == OP_INS && !have_free && !bump_ok) begin
          status_nx = ST_FULL;
        end else if (op_r == OP_DEL && rd_prev_next != target_r) begin
          status_nx = ST_LINK;
        end else if (op_r == OP_NOP) begin
          status_nx = ST_OK;
        end else if (op_r == OP_INS) begin
          state_nx  = WR_NEW;
          done_nx   = 1'b0;
          we_nx     = 1'b1;
          idx_nx    = f_sel;
          din_nx    = {rd_prev_next, rule_r, fields_r};
          pop       = have_free;
          take_bump = !have_free;
        end else begin
          state_nx = WR_PREV;
          done_nx  = 1'b0;
          we_nx    = 1'b1;
          idx_nx   = prev_r;
          din_nx   = {rd_tgt_next, rd_prev[LOW-1:0]};
        end
      end
      WR_NEW: begin
        state_nx = WR_PREV;
        we_nx    = 1'b1;
        idx_nx   = prev_r;
        din_nx   = {f_r, prev_low};
      end
      WR_PREV: begin
        if (op_r == OP_INS) begin
          state_nx  = DONE;
          done_nx   = 1'b1;
          status_nx = ST_OK;
        end else begin
          state_nx = WR_CLR;
          we_nx    = 1'b1;
          idx_nx   = target_r;
        end
      end
      WR_CLR: begin
        state_nx  = DONE;
        done_nx   = 1'b1;
        status_nx = ST_OK;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      we          <= 1'b0;
      din         <= '0;
      wr_index    <= '0;
      done        <= 1'b0;
      status      <= '0;
      alloc_index <= '0;
      sp          <= '0;
      bump        <= INIT_C;
      op_r        <= '0;
      prev_r      <= '0;
      target_r    <= '0;
      rule_r      <= '0;
      fields_r    <= '0;
      prev_low    <= '0;
      tgt_next    <= '0;
      f_r         <= '0;
    end else begin
      state     <= state_nx;
      cmd_ready <= (state_nx == IDLE);
      we        <= we_nx;
      din       <= din_nx;
      wr_index  <= idx_nx;
      done      <= done_nx;
      status    <= status_nx;
      if (cmd_valid && cmd_ready) begin
        op_r     <= cmd_op;
        prev_r   <= cmd_prev;
        target_r <= cmd_target;
        rule_r   <= cmd_rule_id;
        fields_r <= cmd_fields;
      end
      if (state == READ) begin
        prev_low <= rd_prev[LOW-1:0];
        tgt_next <= rd_tgt_next;
        f_r      <= f_sel;
      end
      if (pop)       sp <= sp_dec;
      else if (push) sp <= sp + 1'b1;
      if (take_bump) bump <= bump + 1'b1;
      if (state == WR_PREV && op_r == OP_INS) alloc_index <= f_r;
    end
  end

  always_ff @(posedge clk) begin
    if (we)   shadow[wr_index[AW-1:0]] <= din;
    if (push) free_stack[sp[AW-1:0]]   <= target_r;
  end
endmodule

// File: tb/tb_g3_table_updater.sv
// Bench for g3_table_updater: directed and random commands against a list-level table model.
module tb_g3_table_updater;
  localparam int unsigned TES = 7;
  localparam int unsigned IU  = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [10:0]  cmd_prev, cmd_target, cmd_rule_id;
  logic [148:0] cmd_fields;
  logic         we;
  logic [170:0] din;
  logic [10:0]  wr_index;
  logic         done;
  logic [1:0]   status;
  logic [10:0]  alloc_index;

  g3_table_updater #(
    .TABLE_ENTRY_SIZE(TES),
    .INDEX_BIT_LEN(11),
    .ENTRY_DATA_WIDTH(171),
    .COMMAND_BIT_LEN(2),
    .INIT_USED(IU)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_prev(cmd_prev), .cmd_target(cmd_target),
    .cmd_rule_id(cmd_rule_id), .cmd_fields(cmd_fields), .we(we), .din(din),
    .wr_index(wr_index), .done(done), .status(status), .alloc_index(alloc_index)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: table contents, LIFO free list, bump allocator, and the chain from slot 1.
  logic [170:0] tbl [8];
  logic [10:0]  freel [$];
  int           bump;
  logic [10:0]  m_alloc;
  logic [10:0]  chain [$];

  logic [1:0]   exp_st;
  int           exp_nw, exp_lat;
  logic [10:0]  exp_wi [2];
  logic [170:0] exp_wd [2];

  task automatic chk(input string tag, input logic [170:0] got, input logic [170:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [148:0] rnd_fields();
    logic [159:0] x;
    x = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return x[148:0];
  endfunction

  task automatic model(input logic [1:0] op, input logic [10:0] p, input logic [10:0] t,
                       input logic [10:0] r, input logic [148:0] fl);
    logic [10:0] f;
    exp_st = 2'b00; exp_nw = 0; exp_lat = 2;
    exp_wi[0] = '0; exp_wi[1] = '0; exp_wd[0] = '0; exp_wd[1] = '0;
    if (op == 2'b11) exp_st = 2'b11;
    else if (p == 0 || p > TES || (op == 2'b10 && (t == 0 || t > TES))) exp_st = 2'b11;
    else if (op == 2'b01 && freel.size() == 0 && bump > TES) exp_st = 2'b01;
    else if (op == 2'b10 && tbl[p[2:0]][170:160] != t) exp_st = 2'b10;
    else if (op == 2'b01) begin
      if (freel.size() != 0) f = freel.pop_back();
      else begin f = 11'(bump); bump++; end
      exp_wi[0] = f; exp_wd[0] = {tbl[p[2:0]][170:160], r, fl};
      exp_wi[1] = p; exp_wd[1] = {f, tbl[p[2:0]][159:0]};
      tbl[f[2:0]] = exp_wd[0];
      tbl[p[2:0]] = exp_wd[1];
      exp_nw = 2; exp_lat = 4; m_alloc = f;
    end else if (op == 2'b10) begin
      exp_wi[0] = p; exp_wd[0] = {tbl[t[2:0]][170:160], tbl[p[2:0]][159:0]};
      exp_wi[1] = t; exp_wd[1] = '0;
      tbl[p[2:0]] = exp_wd[0];
      tbl[t[2:0]] = '0;
      freel.push_back(t);
      exp_nw = 2; exp_lat = 4;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [10:0] p, input logic [10:0] t,
                     input logic [10:0] r, input logic [148:0] fl);
    int nw, lat, w;
    logic [10:0]  gi [4];
    logic [170:0] gd [4];
    model(op, p, t, r, fl);
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_wait", 171'(cmd_ready), 171'(1));
    cmd_op = op; cmd_prev = p; cmd_target = t; cmd_rule_id = r; cmd_fields = fl;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = '0;
    nw = 0; lat = 99;
    for (int k = 1; k <= 8; k++) begin
      if (we) begin
        if (nw < 4) begin gi[nw] = wr_index; gd[nw] = din; end
        nw++;
      end
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    chk("latency", 171'(lat), 171'(exp_lat));
    chk("status", 171'(status), 171'(exp_st));
    chk("nwrites", 171'(nw), 171'(exp_nw));
    for (int i = 0; i < exp_nw && i < nw; i++) begin
      chk("wr_index", 171'(gi[i]), 171'(exp_wi[i]));
      chk("din", gd[i], exp_wd[i]);
    end
    chk("alloc_index", 171'(alloc_index), 171'(m_alloc));
    chk("busy_at_done", 171'(cmd_ready), 171'(0));
    @(negedge clk);
    chk("ready_after", 171'(cmd_ready), 171'(1));
  endtask

  task automatic ins(input int i, input logic [10:0] r);
    run(2'b01, chain[i], 11'd0, r, rnd_fields());
    if (exp_st == 2'b00) chain.insert(i + 1, m_alloc);
  endtask

  task automatic del(input int i);
    run(2'b10, chain[i-1], chain[i], 11'd0, rnd_fields());
    if (exp_st == 2'b00) chain.delete(i);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, sel, g, w;
    logic [10:0] t, nx;
    for (int k = 0; k < 8; k++) tbl[k] = '0;
    bump = IU; m_alloc = '0;
    chain.push_back(11'd1);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_prev = '0; cmd_target = '0;
    cmd_rule_id = '0; cmd_fields = '0;
    #12;
    chk("rst_ready", 171'(cmd_ready), 171'(1));
    chk("rst_we", 171'(we), 171'(0));
    chk("rst_done", 171'(done), 171'(0));
    chk("rst_status", 171'(status), 171'(0));
    chk("rst_alloc", 171'(alloc_index), 171'(0));
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    run(2'b01, 11'd0, 11'd0, 11'd9, rnd_fields());
    ins(0, 11'd5);
    chk("first_alloc", 171'(alloc_index), 171'(2));
    del(1);
    ins(0, 11'd6);
    chk("reuse_freed", 171'(alloc_index), 171'(2));
    ins(0, 11'd7);
    chk("bump_next", 171'(alloc_index), 171'(3));
    run(2'b10, 11'd1, 11'd7, 11'd0, rnd_fields());
    run(2'b00, 11'd1, 11'd0, 11'd0, rnd_fields());
    run(2'b11, 11'd1, 11'd2, 11'd0, rnd_fields());
    run(2'b01, 11'd2047, 11'd0, 11'd1, rnd_fields());
    run(2'b01, 11'd8, 11'd0, 11'd1, rnd_fields());
    run(2'b10, 11'd1, 11'd0, 11'd0, rnd_fields());
    run(2'b10, 11'd1, 11'd8, 11'd0, rnd_fields());

    g = 0;
    while (chain.size() < TES && g < 10) begin ins(0, 11'($urandom)); g++; end
    ins(0, 11'd33);
    chk("full_status", 171'(status), 171'(1));

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        ins($urandom_range(0, chain.size() - 1), 11'($urandom));
      end else if (sel <= 7 && chain.size() > 1) begin
        del($urandom_range(1, chain.size() - 1));
      end else if (sel == 8) begin
        case ($urandom_range(0, 3))
          0: run(2'b11, chain[0], 11'd0, 11'd0, rnd_fields());
          1: run(2'($urandom_range(0, 2)), 11'd0, 11'd1, 11'd0, rnd_fields());
          2: run(2'b01, 11'($urandom_range(TES + 1, 2047)), 11'd0, 11'd0, rnd_fields());
          default: begin
            i  = $urandom_range(0, chain.size() - 1);
            nx = (i + 1 < chain.size()) ? chain[i+1] : 11'd0;
            t  = 11'($urandom_range(1, TES));
            if (t == nx) t = (t == 11'(TES)) ? 11'd1 : t + 11'd1;
            run(2'b10, chain[i], t, 11'd0, rnd_fields());
          end
        endcase
      end else begin
        run(2'b00, chain[$urandom_range(0, chain.size() - 1)], 11'd0, 11'd0, rnd_fields());
      end
    end

    // Abort an INSERT while its first write is on the port.
    while (chain.size() > 1) del(1);
    cmd_op = 2'b01; cmd_prev = 11'd1; cmd_target = '0; cmd_rule_id = 11'd44;
    cmd_fields = rnd_fields(); cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    w = 0;
    while (!we && w < 6) begin @(negedge clk); w++; end
    chk("we_before_abort", 171'(we), 171'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", 171'(we), 171'(0));
    chk("abort_done", 171'(done), 171'(0));
    chk("abort_status", 171'(status), 171'(0));
    chk("abort_ready", 171'(cmd_ready), 171'(1));
    freel.delete(); bump = IU; m_alloc = '0;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    run(2'b01, 11'd1, 11'd0, 11'd55, rnd_fields());
    chk("post_abort_alloc", 171'(alloc_index), 171'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
